// File: rtl/udp_pkt_reader.sv
// Reads one completed half of the ping-pong channel buffer per main-sync falling edge
// and streams it as a framed packet (2 header words + WORDS data words) over valid/ready.
module udp_pkt_reader #(
    parameter int unsigned WORDS = 128,
    parameter logic [15:0] MAGIC = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_msync_n,
    output logic [9:0]  o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_busy,
    output logic        o_ovr
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 11;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
    localparam logic [CW-1:0] N_WORDS   = CW'(WORDS);
    localparam logic [CW-1:0] LAST_IDX  = CW'(WORDS - 1);
    localparam logic [15:0]   WORDS_HDR = 16'(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_prev_msync;
    logic            r_armed, w_armed_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_ovr, w_ovr_nxt;
    logic [15:0]     r_seq, w_seq_nxt;
    logic [7:0]      r_ovr_cnt, w_ovr_cnt_nxt;
    logic [AW-1:0]   r_rd_addr, w_rd_addr_nxt;
    logic [CW-1:0]   r_rd_cnt, w_rd_cnt_nxt;
    logic [CW-1:0]   r_ld_cnt, w_ld_cnt_nxt;
    logic            r_inflight, w_inflight_nxt;
    logic [DW-1:0]   r_fifo [2];
    logic            r_wr_ptr, w_wr_ptr_nxt;
    logic            r_rd_ptr, w_rd_ptr_nxt;
    logic [1:0]      r_occ, w_occ_nxt;
    logic            r_valid, w_valid_nxt;
    logic [DW-1:0]   r_data, w_data_nxt;
    logic            r_sop, w_sop_nxt;
    logic            r_eop, w_eop_nxt;

    logic            w_msync;
    logic            w_accept;
    logic            w_can_load;
    logic            w_have_word;
    logic [DW-1:0]   w_head;
    logic            w_issue;
    logic            w_load;
    logic            w_push;
    logic            w_pop;

    assign w_msync     = r_prev_msync & ~i_msync_n;
    assign w_accept    = r_valid & i_ready;
    assign w_can_load  = ~r_valid | i_ready;
    assign w_have_word = (r_occ != 2'd0) | r_inflight;
    // Skid FIFO head, or the read return itself when the FIFO is empty.
    assign w_head      = (r_occ != 2'd0) ? r_fifo[r_rd_ptr] : i_rd_data;

    always_comb begin
        w_state_nxt    = r_state;
        w_armed_nxt    = r_armed;
        w_busy_nxt     = r_busy;
        w_ovr_nxt      = 1'b0;
        w_seq_nxt      = r_seq;
        w_ovr_cnt_nxt  = r_ovr_cnt;
        w_rd_addr_nxt  = r_rd_addr;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_ld_cnt_nxt   = r_ld_cnt;
        w_inflight_nxt = 1'b0;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_occ_nxt      = r_occ;
        w_valid_nxt    = r_valid;
        w_data_nxt     = r_data;
        w_sop_nxt      = r_sop;
        w_eop_nxt      = r_eop;
        w_issue        = 1'b0;
        w_load         = 1'b0;
        w_push         = 1'b0;
        w_pop          = 1'b0;

        if (w_msync) begin
            if (r_busy) begin
                w_ovr_nxt = 1'b1;
                if (r_ovr_cnt != 8'hFF) w_ovr_cnt_nxt = r_ovr_cnt + 8'd1;
            end else if (!r_armed) begin
                w_armed_nxt = 1'b1;
            end
        end

        // Reads start while header 0 is shown so word 0 is ready right behind header 1.
        if (r_state != S_IDLE && r_rd_cnt < N_WORDS && (r_occ + 2'(r_inflight)) < 2'd2)
            w_issue = 1'b1;
        if (w_issue) begin
            w_rd_cnt_nxt = r_rd_cnt + CW'(1);
            if (r_rd_addr != LAST_ADDR) w_rd_addr_nxt = r_rd_addr + AW'(1);
        end
        w_inflight_nxt = w_issue;

        case (r_state)
            S_IDLE: begin
                if (w_msync && r_armed && !r_busy) begin
                    w_state_nxt   = S_HDR0;
                    w_busy_nxt    = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_data_nxt    = {MAGIC, r_seq};
                    w_sop_nxt     = 1'b1;
                    w_eop_nxt     = 1'b0;
                    w_rd_addr_nxt = '0;
                    w_rd_cnt_nxt  = '0;
                    w_ld_cnt_nxt  = '0;
                end
            end
            S_HDR0: begin
                if (w_accept) begin
                    w_state_nxt = S_HDR1;
                    w_data_nxt  = {r_ovr_cnt, 8'h00, WORDS_HDR};
                    w_sop_nxt   = 1'b0;
                end
            end
            S_HDR1: begin
                if (w_accept) begin
                    w_state_nxt = S_DATA;
                    w_load      = w_have_word;
                    if (!w_have_word) w_valid_nxt = 1'b0;
                end
            end
            S_DATA: begin
                if (w_accept && r_eop) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_eop_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_seq_nxt   = r_seq + 16'd1;
                end else if (w_can_load) begin
                    w_load = w_have_word;
                    if (!w_have_word) w_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_load) begin
            w_valid_nxt  = 1'b1;
            w_data_nxt   = w_head;
            w_sop_nxt    = 1'b0;
            w_eop_nxt    = (r_ld_cnt == LAST_IDX);
            w_ld_cnt_nxt = r_ld_cnt + CW'(1);
            w_pop        = (r_occ != 2'd0);
        end

        w_push = r_inflight & ~(w_load & (r_occ == 2'd0));
        if (w_push) w_wr_ptr_nxt = ~r_wr_ptr;
        if (w_pop)  w_rd_ptr_nxt = ~r_rd_ptr;
        w_occ_nxt = r_occ + 2'(w_push) - 2'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev_msync <= 1'b1;
            r_armed      <= 1'b0;
            r_busy       <= 1'b0;
            r_ovr        <= 1'b0;
            r_seq        <= '0;
            r_ovr_cnt    <= '0;
            r_rd_addr    <= '0;
            r_rd_cnt     <= '0;
            r_ld_cnt     <= '0;
            r_inflight   <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_occ        <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_msync <= i_msync_n;
            r_armed      <= w_armed_nxt;
            r_busy       <= w_busy_nxt;
            r_ovr        <= w_ovr_nxt;
            r_seq        <= w_seq_nxt;
            r_ovr_cnt    <= w_ovr_cnt_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_rd_cnt     <= w_rd_cnt_nxt;
            r_ld_cnt     <= w_ld_cnt_nxt;
            r_inflight   <= w_inflight_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_occ        <= w_occ_nxt;
            r_valid      <= w_valid_nxt;
            r_data       <= w_data_nxt;
            r_sop        <= w_sop_nxt;
            r_eop        <= w_eop_nxt;
        end
    end

    // Skid storage carries no control meaning, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= i_rd_data;
    end

    assign o_rd_addr = r_rd_addr;
    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_sop     = r_sop;
    assign o_eop     = r_eop;
    assign o_busy    = r_busy;
    assign o_ovr     = r_ovr;

endmodule

// File: tb/tb_udp_pkt_reader.sv
// Directed/randomized bench for udp_pkt_reader: a registered buffer model feeds the DUT and
// every accepted packet is compared word by word against a packet built from the buffer contents.
module tb_udp_pkt_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        msync_n, msync1_n;
    logic        ready;
    logic [9:0]  rd_addr, rd_addr1;
    logic [31:0] rd_data, rd_data1;
    logic [31:0] data, data1;
    logic        valid, sop, eop, busy, ovr;
    logic        valid1, sop1, eop1, busy1, ovr1;

    udp_pkt_reader #(.WORDS(128)) u_dut (
        .clk(clk), .rst(rst), .i_msync_n(msync_n), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_data(data), .o_valid(valid), .i_ready(ready), .o_sop(sop), .o_eop(eop),
        .o_busy(busy), .o_ovr(ovr));

    udp_pkt_reader #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_msync_n(msync1_n), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1),
        .o_data(data1), .o_valid(valid1), .i_ready(1'b1), .o_sop(sop1), .o_eop(eop1),
        .o_busy(busy1), .o_ovr(ovr1));

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    always @(posedge clk) begin
        rd_data  <= mem[rd_addr[6:0]];
        rd_data1 <= mem[rd_addr1[6:0]];
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] got_d[$], got1_d[$];
    logic [1:0]  got_f[$], got1_f[$];
    int          got_t[$];
    int          ovr_pulses = 0;
    logic [9:0]  max_addr1 = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    // Observe everything on the falling edge, half a cycle away from the DUT's active edge.
    always @(negedge clk) begin
        if (prev_stall) chk("stall_hold", data, prev_data);
        prev_stall = valid && !ready;
        prev_data  = data;
        if (valid && ready) begin
            got_d.push_back(data);
            got_f.push_back({sop, eop});
            got_t.push_back(cyc);
        end
        if (valid1) begin
            got1_d.push_back(data1);
            got1_f.push_back({sop1, eop1});
        end
        if (ovr) ovr_pulses++;
        if (rd_addr1 > max_addr1) max_addr1 = rd_addr1;
    end

    task automatic clear_q();
        got_d.delete(); got_f.delete(); got_t.delete();
        got1_d.delete(); got1_f.delete();
    endtask

    task automatic msync(output int at);
        @(posedge clk); #1;
        msync_n = 1'b0;
        at = cyc;
        @(posedge clk); #1;
        msync_n = 1'b1;
    endtask

    task automatic run(input bit rnd, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clk); #1;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k++;
        end
        if (busy) chk("timeout_busy", 32'(busy), 32'd0);
        ready = 1'b1;
    endtask

    // Expected packet: {MAGIC,seq}, {ovr,0,words}, then buffer words 0..nw-1.
    task automatic check_pkt(input string tag, input logic [31:0] d[$], input logic [1:0] f[$],
                             input logic [15:0] seq, input logic [7:0] ov, input int nw);
        chk({tag, "_len"}, 32'(d.size()), 32'(nw + 2));
        for (int i = 0; i < d.size() && i < nw + 2; i++) begin
            logic [31:0] e;
            e = (i == 0) ? {16'hA55A, seq} : (i == 1) ? {ov, 8'h00, 16'(nw)} : mem[i-2];
            chk($sformatf("%s_w%0d", tag, i), d[i], e);
            chk($sformatf("%s_f%0d", tag, i), 32'(f[i]), {30'd0, i == 0, i == nw + 1});
        end
    endtask

    initial begin
        int t;
        rst = 1'b1; msync_n = 1'b1; msync1_n = 1'b1; ready = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_sop", 32'(sop), 0);
        chk("rst_eop", 32'(eop), 0);
        chk("rst_data", data, 0);
        chk("rst_addr", 32'(rd_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(ovr), 0);
        @(posedge clk); #1; rst = 1'b0;

        // First msync only arms.
        msync(t);
        repeat (300) @(posedge clk);
        #1;
        chk("arm_nopkt", 32'(got_d.size()), 0);
        chk("arm_busy", 32'(busy), 0);

        // Full-rate packet: first header one clock after the msync pulse, no bubbles.
        clear_q();
        msync(t);
        run(1'b0, 1000);
        check_pkt("pkt0", got_d, got_f, 16'd0, 8'd0, 128);
        chk("pkt0_lat", 32'(got_t[0]), 32'(t + 1));
        chk("pkt0_gapless", 32'(got_t[129] - got_t[0]), 32'd129);
        chk("pkt0_addr_end", 32'(rd_addr), 32'd127);

        // Random back-pressure with data = address.
        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
        clear_q();
        msync(t);
        run(1'b1, 5000);
        check_pkt("pkt1", got_d, got_f, 16'd1, 8'd0, 128);

        // Overrun: headers go through, then stall and fire another msync.
        clear_q();
        ovr_pulses = 0;
        msync(t);
        @(posedge clk); #1; ready = 1'b1;
        @(posedge clk); #1; ready = 1'b0;
        msync(t);
        repeat (500) @(posedge clk);
        #1;
        chk("ovr_busy_held", 32'(busy), 1);
        run(1'b0, 2000);
        chk("ovr_pulses", 32'(ovr_pulses), 1);
        check_pkt("pkt2", got_d, got_f, 16'd2, 8'd0, 128);

        clear_q();
        msync(t);
        run(1'b1, 5000);
        check_pkt("pkt3", got_d, got_f, 16'd3, 8'd1, 128);

        // Sequence number wrap.
        force u_dut.r_seq = 16'hFFFF;
        @(posedge clk); #1;
        release u_dut.r_seq;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        clear_q();
        msync(t);
        run(1'b0, 1000);
        check_pkt("pkt_ffff", got_d, got_f, 16'hFFFF, 8'd1, 128);
        clear_q();
        msync(t);
        run(1'b1, 5000);
        check_pkt("pkt_wrap", got_d, got_f, 16'h0000, 8'd1, 128);

        // Reset mid-DATA abandons the packet and disarms.
        msync(t);
        repeat (20) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        @(posedge clk); #1; rst = 1'b0;
        clear_q();
        msync(t);
        repeat (300) @(posedge clk);
        #1;
        chk("rearm_nopkt", 32'(got_d.size()), 0);
        chk("rearm_busy", 32'(busy), 0);
        msync(t);
        run(1'b1, 5000);
        check_pkt("pkt_after_rst", got_d, got_f, 16'd0, 8'd0, 128);

        // Single-word build.
        mem[0] = $urandom;
        clear_q();
        @(posedge clk); #1; msync1_n = 1'b0;
        @(posedge clk); #1; msync1_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("w1_arm_nopkt", 32'(got1_d.size()), 0);
        @(posedge clk); #1; msync1_n = 1'b0;
        @(posedge clk); #1; msync1_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check_pkt("w1", got1_d, got1_f, 16'd0, 8'd0, 1);
        chk("w1_addr_max", 32'(max_addr1), 0);
        chk("w1_busy", 32'(busy1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
